// File: rtl/conv_mac_engine_pkg.sv
// Shared CNN datapath definitions: default widths, conv FSM states
// and output saturation limits.
package conv_pkg;

  localparam int DATA_W   = 8;
  localparam int WEIGHT_W = 8;
  localparam int ACC_W    = 24;
  localparam int OUT_W    = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MAC  = 2'd1;
  localparam state_t S_BIAS = 2'd2;
  localparam state_t S_OUT  = 2'd3;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_mac_engine_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and
// registered accumulator output.
module conv_mac_unit #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [WEIGHT_W-1:0] b,
  output logic signed [ACC_W-1:0]    acc
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;

  assign prod   = a * b;
  assign prod_x = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_x;
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Multi-channel KxK convolution engine: one tap per cycle MAC,
// then bias, optional ReLU and saturation to OUT_W.
module conv_mac_engine #(
  parameter int K        = 5,
  parameter int N_CH     = 1,
  parameter int DATA_W   = conv_pkg::DATA_W,
  parameter int WEIGHT_W = conv_pkg::WEIGHT_W,
  parameter int BIAS_W   = 9,
  parameter int ACC_W    = conv_pkg::ACC_W,
  parameter int OUT_W    = conv_pkg::OUT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_CH*K*K*DATA_W-1:0]    win_data,
  input  logic [N_CH*K*K*WEIGHT_W-1:0]  weights,
  input  logic signed [BIAS_W-1:0]      bias,
  input  logic                          relu_en,
  output logic                          busy,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sat
);

  import conv_pkg::*;

  localparam int TAPS  = N_CH * K * K;
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  // Sized so a full window of worst-case products cannot wrap.
  if (ACC_W < DATA_W + WEIGHT_W + $clog2(TAPS) + 1) begin : g_acc_chk
    $error("conv_mac_engine: ACC_W too small for TAPS");
  end

  state_t                      state;
  logic [CNT_W-1:0]            tap_cnt;
  logic [TAPS*DATA_W-1:0]      d_reg;
  logic [TAPS*WEIGHT_W-1:0]    w_reg;
  logic signed [BIAS_W-1:0]    b_reg;
  logic                        relu_reg;
  logic signed [ACC_W-1:0]     acc;
  logic signed [DATA_W-1:0]    tap_d;
  logic signed [WEIGHT_W-1:0]  tap_w;
  logic                        clr;
  logic                        mac_en;
  logic signed [ACC_W:0]       sum;
  logic signed [63:0]          sum_x;
  logic signed [OUT_W-1:0]     res;
  logic                        res_sat;

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign clr       = (state == S_IDLE) && start;
  assign mac_en    = (state == S_MAC);

  assign tap_d = d_reg[32'(tap_cnt)*DATA_W +: DATA_W];
  assign tap_w = w_reg[32'(tap_cnt)*WEIGHT_W +: WEIGHT_W];

  conv_mac_unit #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (mac_en),
    .a     (tap_d),
    .b     (tap_w),
    .acc   (acc)
  );

  assign sum = {acc[ACC_W-1], acc}
             + {{(ACC_W + 1 - BIAS_W){b_reg[BIAS_W-1]}}, b_reg};
  assign sum_x = {{(63 - ACC_W){sum[ACC_W]}}, sum};

  always_comb begin
    res     = sum[OUT_W-1:0];
    res_sat = 1'b0;
    if (relu_reg && sum[ACC_W]) begin
      res = '0;
    end else if (sum_x > sat_max(OUT_W)) begin
      res     = OUT_W'(sat_max(OUT_W));
      res_sat = 1'b1;
    end else if (sum_x < sat_min(OUT_W)) begin
      res     = OUT_W'(sat_min(OUT_W));
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tap_cnt  <= '0;
      d_reg    <= '0;
      w_reg    <= '0;
      b_reg    <= '0;
      relu_reg <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            d_reg    <= win_data;
            w_reg    <= weights;
            b_reg    <= bias;
            relu_reg <= relu_en;
            tap_cnt  <= '0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          if (tap_cnt == LAST) begin
            state <= S_BIAS;
          end else begin
            tap_cnt <= tap_cnt + 1'b1;
          end
        end
        S_BIAS: begin
          out_data <= res;
          out_sat  <= res_sat;
          state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_mac_engine.md
# conv_mac_engine

Parametrised, sequential multi-channel convolution engine that computes one output pixel per transaction. It covers a K×K window across N_CH input channels by multiply-accumulating one tap per cycle, then adds a bias, applies optional ReLU and saturates the result. It sits between the window/line-buffer stage and the pooling stage of the CNN datapath. It is the successor to the single-channel 5×5 conv1 block and adds a start/done handshake, output backpressure, multi-channel support and saturation.

## Interface
- K, 5, kernel side length; TAPS = N_CH*K*K
- N_CH, 1, input channels
- DATA_W, 8, signed activation width
- WEIGHT_W, 8, signed weight width
- BIAS_W, 9, signed bias width
- ACC_W, 24, signed accumulator width; must be ≥ DATA_W+WEIGHT_W+clog2(TAPS)+1
- OUT_W, 16, signed output width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a computation; accepted only in IDLE
- win_data  in  TAPS*DATA_W  flattened window; tap t at [t*DATA_W +: DATA_W]
- weights  in  TAPS*WEIGHT_W  flattened kernel, same tap order
- bias  in  BIAS_W  signed bias
- relu_en  in  1  clamp negative results to 0
- busy  out  1  high in every state except IDLE
- out_data  out  OUT_W  signed result
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_sat  out  1  result was clipped; qualified by out_valid

## Operation
- Tap order: t = ch*K*K + row*K + col.
- States: IDLE, MAC, BIAS, OUT.
- IDLE: when start=1, latch win_data, weights, bias and relu_en into internal registers; clear acc and tap_cnt; go to MAC. In all other states, start is ignored and the operands are not resampled.
- MAC: acc += sext(d[tap_cnt]) * sext(w[tap_cnt]); tap_cnt increments each cycle. After tap TAPS-1, go to BIAS.
- BIAS: acc += sext(bias). Then:
  - If relu_en=1 and acc<0, the result is 0 and sat=0.
  - Otherwise, if acc > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1 and sat=1.
  - Otherwise, if acc < -2^(OUT_W-1), the result is -2^(OUT_W-1) and sat=1.
  - Otherwise, the result is acc[OUT_W-1:0] and sat=0.
  - Register out_data and out_sat; go to OUT.
- OUT: out_valid=1, and out_data/out_sat are held stable. On out_valid && out_ready, go to IDLE.
- The accumulator never wraps, provided the ACC_W constraint holds. An elaboration-time check fails the build if the constraint is violated.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_sat=0; state=IDLE, acc=0, tap_cnt=0.
- Reset asserted mid-transaction aborts immediately, regardless of state; no result is produced.
- Counting the start-accept edge as edge 0, the MAC occupies edges 1..TAPS, BIAS is edge TAPS+1, and out_valid rises after edge TAPS+1.
- Default parameters (TAPS=25): out_valid is high from cycle 26.
- Handshake completes on the first edge with out_valid && out_ready; out_valid falls after that edge.
- The earliest next start is accepted one cycle after the handshake, while back in IDLE. A start held high through OUT is therefore accepted in that IDLE cycle. Throughput: one result per TAPS+3 cycles.
- busy rises on the edge after start is accepted and falls on the edge that completes the handshake.

## Structure
- Shared package conv_pkg:
  - state enum (IDLE/MAC/BIAS/OUT)
  - saturation-limit helper functions
  - default width localparams (DATA_W, WEIGHT_W, ACC_W, OUT_W), shared with pooling/fc blocks
- Sub-module conv_mac_unit: one signed multiply plus accumulate-with-clear, registered acc output, parametrised on DATA_W/WEIGHT_W/ACC_W.
- The top level holds the FSM, tap counter, operand registers, tap multiplexer and the bias/ReLU/saturation stage.

## Test plan
- Unity, defaults: all data=1, weights=1, bias=0, relu_en=0 → out_data=25, out_sat=0, out_valid at cycle 26; busy high cycles 1–26.
- Positive saturation, N_CH=3: data=127, weights=127, bias=0 → acc=1209675, out_data=32767, out_sat=1.
- Negative and ReLU: data=1, weights=-1, bias=-3. With relu_en=0 → out_data=-28. With relu_en=1 → out_data=0, out_sat=0. With data=-128, weights=127, N_CH=3, relu_en=0 → out_data=-32768, out_sat=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulsing start and changing win_data during that time → out_data stable and no new transaction. Releasing out_ready gives exactly one handshake, and the next start is accepted one cycle later.
- Reset mid-MAC: assert rst_n=0 at tap 12 → outputs immediately 0 and IDLE. A fresh start with data=2, weights=3, bias=5 yields 155.
- Back-to-back: start held high continuously with out_ready=1 → results spaced exactly TAPS+3 cycles apart, each matching a reference model.
